spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 175 +++++++++++++++++
 tb/tb_spi_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave with 2-flop synchronised pins, one-byte transmit holding register
// and continuous byte framing while chip select stays low.
module spi_slave #(
    parameter int SPI_MODE                   = 0,
    parameter int SPI_MIN_CLOCK_PER_HALF_BIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_SCLK,
    input  logic       i_CS,
    input  logic       i_MOSI,
    output logic       o_MISO,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_DATA,
    output logic       o_TX_READY,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_DATA,
    output logic       o_busy
);

    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    // Two sync flops plus one edge-detect flop need at least this half-period.
    if (SPI_MIN_CLOCK_PER_HALF_BIT < 4) begin : g_half_bit_check
        $error("spi_slave: SPI_MIN_CLOCK_PER_HALF_BIT must be at least 4");
    end

    typedef enum logic [1:0] {
        SLV_IDLE = 2'b00,
        SLV_XFER = 2'b01
    } slv_state_t;

    slv_state_t state;

    logic       sclk_meta, sclk_sync, sclk_d;
    logic       cs_meta, cs_sync, cs_d;
    logic       mosi_meta, mosi_sync;
    logic [1:0] settle;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       miso_bit;
    logic       miso_en;
    logic       reload_pending;

    logic [7:0] hold_data;
    logic       hold_full;

    logic       lead_edge, trail_edge, sample_edge, drive_edge;
    logic       cs_fall, cs_rise;
    logic       start_xfer, reload, consume;
    logic [7:0] next_byte;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_meta <= CPOL;
            sclk_sync <= CPOL;
            sclk_d    <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_d      <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            settle    <= 2'd0;
        end else begin
            sclk_meta <= i_SCLK;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            cs_meta   <= i_CS;
            cs_sync   <= cs_meta;
            cs_d      <= cs_sync;
            mosi_meta <= i_MOSI;
            mosi_sync <= mosi_meta;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
        end
    end

    always_comb begin
        lead_edge   = (sclk_sync != CPOL) && (sclk_d == CPOL);
        trail_edge  = (sclk_sync == CPOL) && (sclk_d != CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        drive_edge  = CPHA ? lead_edge : trail_edge;
        // A CS already low when reset releases must not look like a fresh select.
        cs_fall     = (settle == 2'd3) && cs_d && !cs_sync;
        cs_rise     = !cs_d && cs_sync;
        next_byte   = hold_full ? hold_data : 8'hFF;
        start_xfer  = (state == SLV_IDLE) && cs_fall;
        reload      = (state == SLV_XFER) && !cs_rise && drive_edge && reload_pending;
        consume     = (start_xfer || reload) && hold_full;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= SLV_IDLE;
            bit_cnt        <= 3'd0;
            rx_shift       <= 8'h00;
            tx_shift       <= 8'h00;
            miso_bit       <= 1'b0;
            miso_en        <= 1'b0;
            reload_pending <= 1'b0;
            o_RX_DV        <= 1'b0;
            o_RX_DATA      <= 8'h00;
        end else begin
            o_RX_DV <= 1'b0;
            case (state)
                SLV_IDLE: begin
                    if (start_xfer) begin
                        state          <= SLV_XFER;
                        bit_cnt        <= 3'd0;
                        reload_pending <= 1'b0;
                        miso_en        <= 1'b1;
                        miso_bit       <= next_byte[7];
                        tx_shift       <= CPHA ? next_byte : {next_byte[6:0], 1'b0};
                    end
                end
                SLV_XFER: begin
                    if (cs_rise) begin
                        state          <= SLV_IDLE;
                        bit_cnt        <= 3'd0;
                        reload_pending <= 1'b0;
                        miso_en        <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[6:0], mosi_sync};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                o_RX_DATA      <= {rx_shift[6:0], mosi_sync};
                                o_RX_DV        <= 1'b1;
                                reload_pending <= 1'b1;
                            end
                        end
                        if (drive_edge) begin
                            if (reload_pending) begin
                                miso_bit       <= next_byte[7];
                                tx_shift       <= {next_byte[6:0], 1'b0};
                                reload_pending <= 1'b0;
                            end else begin
                                miso_bit <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state          <= SLV_IDLE;
                    bit_cnt        <= 3'd0;
                    reload_pending <= 1'b0;
                    miso_en        <= 1'b0;
                end
            endcase
        end
    end

    // A load coinciding with a consume replaces the byte being taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else if (i_TX_DV && (!hold_full || consume)) begin
            hold_data <= i_TX_DATA;
            hold_full <= 1'b1;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    assign o_MISO     = miso_en ? miso_bit : 1'bz;
    assign o_TX_READY = !hold_full;
    assign o_busy     = (state == SLV_XFER);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, bit-banged master tasks,
// rx scoreboard queue and a holding-register model per instance.
module tb_spi_slave;

    localparam int HB = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sclk;
    logic [3:0] cs;
    logic [3:0] tx_dv;
    logic       mosi;
    logic [7:0] tx_data [4];
    wire  [3:0] miso;
    wire  [3:0] tx_ready;
    wire  [3:0] rx_dv;
    wire  [3:0] busy;
    wire  [7:0] rx_data [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .SPI_MODE(g),
            .SPI_MIN_CLOCK_PER_HALF_BIT(4)
        ) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_SCLK(sclk[g]),
            .i_CS(cs[g]),
            .i_MOSI(mosi),
            .o_MISO(miso[g]),
            .i_TX_DV(tx_dv[g]),
            .i_TX_DATA(tx_data[g]),
            .o_TX_READY(tx_ready[g]),
            .o_RX_DV(rx_dv[g]),
            .o_RX_DATA(rx_data[g]),
            .o_busy(busy[g])
        );
    end

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic       model_full [4];
    logic [7:0] model_data [4];
    logic [7:0] slot_exp;
    logic [7:0] b2b_tx [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: mode %0d got byte %02h expected no byte", m, rx_data[m]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", {24'h0, rx_data[m]}, {24'h0, mon_exp});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time %0t reached limit 900000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Next byte slot takes the held byte, or idle-high data when nothing is held.
    function automatic logic [7:0] model_take(input int m);
        logic [7:0] v;
        v = model_full[m] ? model_data[m] : 8'hFF;
        model_full[m] = 1'b0;
        return v;
    endfunction

    task automatic tx_load(input int m, input logic [7:0] d);
        int t;
        t = 0;
        while (tx_ready[m] !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        if (tx_ready[m] !== 1'b1) check("tx_ready_wait", {31'h0, tx_ready[m]}, 32'h1);
        tx_dv[m]   = 1'b1;
        tx_data[m] = d;
        tick(1);
        tx_dv[m]      = 1'b0;
        model_full[m] = 1'b1;
        model_data[m] = d;
    endtask

    task automatic cs_assert(input int m);
        cs[m]    = 1'b0;
        slot_exp = model_take(m);
        tick(HB);
    endtask

    task automatic cs_release(input int m);
        tick(HB);
        cs[m] = 1'b1;
        tick(10);
    endtask

    task automatic spi_bits(input int m, input logic [7:0] d, input int nbits,
                            output logic [7:0] got, output bit stable);
        bit   cpol, cpha;
        logic b;
        cpol   = (m >= 2);
        cpha   = (m % 2) == 1;
        got    = 8'h00;
        stable = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = d[i];
                tick(HB);
                b = miso[m];
                sclk[m] = ~cpol;
                tick(5);
                if (miso[m] !== b) stable = 1'b0;
                tick(HB - 5);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = d[i];
                tick(HB);
                b = miso[m];
                sclk[m] = cpol;
                tick(5);
                if (miso[m] !== b) stable = 1'b0;
                tick(HB - 5);
            end
            got[i] = b;
        end
    endtask

    task automatic spi_byte(input int m, input logic [7:0] d, input bit more);
        logic [7:0] got;
        bit         st;
        exp_q.push_back(d);
        spi_bits(m, d, 8, got, st);
        check("miso_byte", {24'h0, got}, {24'h0, slot_exp});
        check("miso_stable", {31'h0, st}, 32'h1);
        if (more) slot_exp = model_take(m);
    endtask

    task automatic check_reset(input int m);
        check("rst_rx_dv", {31'h0, rx_dv[m]}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data[m]}, 32'h0);
        check("rst_tx_ready", {31'h0, tx_ready[m]}, 32'h1);
        check("rst_busy", {31'h0, busy[m]}, 32'h0);
    endtask

    task automatic session_done(input int m);
        check("rx_pending", exp_q.size(), 32'h0);
        check("busy_idle", {31'h0, busy[m]}, 32'h0);
    endtask

    initial begin
        logic [7:0] x, y, r, got;
        bit         st;
        int         m, t;
        sclk  = 4'b1100;
        cs    = 4'hF;
        tx_dv = 4'h0;
        mosi  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_data[i]    = 8'h00;
            model_full[i] = 1'b0;
            model_data[i] = 8'h00;
        end
        rst = 1'b1;
        tick(3);
        for (int i = 0; i < 4; i++) check_reset(i);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 4; i++) begin
            tx_load(i, 8'hA5);
            check("tx_ready_after_load", {31'h0, tx_ready[i]}, 32'h0);
            cs_assert(i);
            spi_byte(i, 8'h3C, 1'b0);
            cs_release(i);
            session_done(i);
            check("tx_ready_after_xfer", {31'h0, tx_ready[i]}, 32'h1);
        end

        for (int k = 0; k < 5; k++) b2b_tx[k] = 8'($urandom);
        tx_load(0, b2b_tx[0]);
        cs_assert(0);
        fork
            begin
                for (int k = 0; k < 5; k++) spi_byte(0, 8'(k + 1), k < 4);
            end
            begin
                for (int k = 1; k < 5; k++) begin
                    t = 0;
                    while (rx_dv[0] !== 1'b1 && t < 2000) begin
                        tick(1);
                        t++;
                    end
                    if (rx_dv[0] !== 1'b1) check("b2b_rx_dv_wait", {31'h0, rx_dv[0]}, 32'h1);
                    tx_load(0, b2b_tx[k]);
                end
            end
        join
        cs_release(0);
        session_done(0);

        for (int i = 0; i < 4; i += 3) begin
            check("noload_ready_before", {31'h0, tx_ready[i]}, 32'h1);
            cs_assert(i);
            spi_byte(i, 8'($urandom), 1'b0);
            cs_release(i);
            session_done(i);
            check("noload_ready_after", {31'h0, tx_ready[i]}, 32'h1);
        end

        x = 8'($urandom);
        y = 8'($urandom);
        tx_load(0, x);
        cs_assert(0);
        tx_load(0, y);
        spi_bits(0, 8'($urandom), 5, got, st);
        check("partial_miso", {27'h0, got[7:3]}, {27'h0, slot_exp[7:3]});
        cs_release(0);
        check("abort_hold_kept", {31'h0, tx_ready[0]}, 32'h0);
        session_done(0);
        cs_assert(0);
        spi_byte(0, 8'h81, 1'b0);
        cs_release(0);
        session_done(0);

        tx_load(0, 8'($urandom));
        cs_assert(0);
        spi_bits(0, 8'($urandom), 4, got, st);
        rst = 1'b1;
        tick(2);
        check_reset(0);
        rst = 1'b0;
        model_full[0] = 1'b0;
        tick(20);
        check("busy_after_rst", {31'h0, busy[0]}, 32'h0);
        cs[0] = 1'b1;
        tick(10);
        cs_assert(0);
        spi_byte(0, 8'($urandom), 1'b0);
        cs_release(0);
        session_done(0);

        for (int it = 0; it < 8; it++) begin
            m = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) tx_load(m, 8'($urandom));
            cs_assert(m);
            spi_byte(m, 8'($urandom), 1'b0);
            cs_release(m);
            session_done(m);
            check("rand_tx_ready", {31'h0, tx_ready[m]}, {31'h0, !model_full[m]});
        end

        tick(10);
        check("final_rx_pending", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
